// File: rtl/btn_event_arbiter.sv
// Debounced push-button event source: per-button synchronizer and stability filter, rising-edge
// pending bits, round-robin arbitration into a small event queue with a sticky overflow flag.
module btn_event_arbiter #(
  parameter int unsigned NUM_BTN       = 4,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_BTN-1:0]         btn_in,
  output logic                       ev_valid,
  output logic [$clog2(NUM_BTN)-1:0] ev_id,
  input  logic                       ev_ready,
  output logic [NUM_BTN-1:0]         btn_level,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int unsigned IdW  = $clog2(NUM_BTN);
  localparam int unsigned CntW = $clog2(STABLE_CYCLES);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [NUM_BTN-1:0] level_q, level_d, level_prev_q;
  logic [NUM_BTN-1:0] pending_q, pending_d, armed_q, armed_d;
  logic [NUM_BTN-1:0] rise, grant;
  logic [CntW-1:0]    cnt_q [NUM_BTN];
  logic [CntW-1:0]    cnt_d [NUM_BTN];
  logic [1:0]         settle_q, settle_d;
  logic [IdW-1:0]     start_q, start_d, grant_id;
  logic               grant_vld;
  logic [IdW-1:0]     mem_q [FIFO_DEPTH];
  logic [AW:0]        wptr_q, rptr_q;
  logic               full, empty, push, pop;
  logic               overflow_q, overflow_d, ovf_set;

  function automatic logic [IdW-1:0] rr_idx(input logic [IdW-1:0] start, input int unsigned off);
    return IdW'((32'(start) + off) % NUM_BTN);
  endfunction

  // Stability filter: the level only follows sync after STABLE_CYCLES consecutive differences.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // A button only becomes armed once it has been seen released after reset, so a button held
  // through reset release produces no event. The settle count skips the reset-cleared sync stages.
  assign settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
  assign armed_d  = armed_q | ({NUM_BTN{settle_q == 2'd2}} & ~sync2_q);
  assign rise     = level_q & ~level_prev_q & armed_q;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = ~empty & ev_ready;
  assign push  = grant_vld;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (!grant_vld && !full && pending_q[rr_idx(start_q, i)]) begin
        grant_vld                   = 1'b1;
        grant_id                    = rr_idx(start_q, i);
        grant[rr_idx(start_q, i)]   = 1'b1;
      end
    end
  end

  assign start_d    = grant_vld ? rr_idx(grant_id, 1) : start_q;
  assign pending_d  = (pending_q & ~grant) | rise;
  // A press is lost only if its button is still pending and not being granted this cycle.
  assign ovf_set    = |(rise & pending_q & ~grant);
  assign overflow_d = ovf_set | (overflow_q & ~ovf_clr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      pending_q    <= '0;
      armed_q      <= '0;
      settle_q     <= '0;
      start_q      <= '0;
      overflow_q   <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync1_q      <= btn_in;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      pending_q    <= pending_d;
      armed_q      <= armed_d;
      settle_q     <= settle_d;
      start_q      <= start_d;
      overflow_q   <= overflow_d;
      cnt_q        <= cnt_d;
      if (push) begin
        mem_q[wptr_q[AW-1:0]] <= grant_id;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
    end
  end

  assign ev_valid  = ~empty;
  assign ev_id     = mem_q[rptr_q[AW-1:0]];
  assign btn_level = level_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter with NUM_BTN=4, STABLE_CYCLES=4, FIFO_DEPTH=4.
module tb_btn_event_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_in;
  logic       ev_valid;
  logic [1:0] ev_id;
  logic       ev_ready;
  logic [3:0] btn_level;
  logic       overflow;
  logic       ovf_clr;

  int checks   = 0;
  int failures = 0;

  btn_event_arbiter #(
    .NUM_BTN      (4),
    .STABLE_CYCLES(4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .ev_valid (ev_valid),
    .ev_id    (ev_id),
    .ev_ready (ev_ready),
    .btn_level(btn_level),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int b);
    btn_in[b] = 1'b1;
    tick(7);
    btn_in[b] = 1'b0;
    tick(8);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(4);
  endtask

  task automatic test_reset();
    reset = 1'b0; btn_in = '0; ev_ready = 1'b0; ovf_clr = 1'b0;
    #2;
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL reset_ev_valid got=%0b exp=0", ev_valid); end
    checks++; if (ev_id !== 2'd0) begin failures++; $display("FAIL reset_ev_id got=%0d exp=0", ev_id); end
    checks++; if (btn_level !== 4'b0) begin failures++; $display("FAIL reset_level got=%b exp=0000", btn_level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    tick(2);
    reset = 1'b1;
    tick(4);
  endtask

  task automatic test_latency();
    btn_in = 4'b0100;
    tick(7);
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL lat_edge7_valid got=%0b exp=0", ev_valid); end
    tick(1);
    checks++; if (ev_valid !== 1'b1) begin failures++; $display("FAIL lat_edge8_valid got=%0b exp=1", ev_valid); end
    checks++; if (ev_id !== 2'd2) begin failures++; $display("FAIL lat_id got=%0d exp=2", ev_id); end
    checks++; if (btn_level !== 4'b0100) begin failures++; $display("FAIL lat_level got=%b exp=0100", btn_level); end
    btn_in = '0;
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL lat_pop got=%0b exp=0", ev_valid); end
    tick(8);
    checks++; if (btn_level !== 4'b0) begin failures++; $display("FAIL lat_release got=%b exp=0000", btn_level); end
  endtask

  task automatic test_glitch();
    logic [3:0] lvl_seen;
    logic       vld_seen;
    lvl_seen = '0;
    vld_seen = 1'b0;
    btn_in = 4'b0010;
    repeat (3) begin
      tick(1);
      lvl_seen |= btn_level; vld_seen |= ev_valid;
    end
    btn_in = '0;
    repeat (12) begin
      tick(1);
      lvl_seen |= btn_level; vld_seen |= ev_valid;
    end
    checks++; if (lvl_seen !== 4'b0) begin failures++; $display("FAIL glitch_level got=%b exp=0000", lvl_seen); end
    checks++; if (vld_seen !== 1'b0) begin failures++; $display("FAIL glitch_valid got=%0b exp=0", vld_seen); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL glitch_overflow got=%0b exp=0", overflow); end
  endtask

  task automatic test_burst(input int round);
    logic [1:0] ids [4];
    int n, first, last;
    n = 0; first = -1; last = -1;
    for (int k = 0; k < 4; k++) ids[k] = 2'bxx;
    btn_in   = 4'hF;
    ev_ready = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      tick(1);
      if (ev_valid === 1'b1) begin
        if (n < 4) ids[n] = ev_id;
        if (n == 0) first = t;
        last = t;
        n++;
      end
    end
    checks++; if (n != 4) begin failures++; $display("FAIL burst%0d_count got=%0d exp=4", round, n); end
    checks++; if (first != 8) begin failures++; $display("FAIL burst%0d_first got=%0d exp=8", round, first); end
    checks++; if (last - first != 3) begin failures++; $display("FAIL burst%0d_span got=%0d exp=3", round, last - first); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ids[k] !== 2'(k)) begin
        failures++; $display("FAIL burst%0d_id%0d got=%0d exp=%0d", round, k, ids[k], k);
      end
    end
    btn_in   = '0;
    ev_ready = 1'b0;
    tick(10);
  endtask

  task automatic test_overflow();
    ev_ready = 1'b0;
    for (int b = 0; b < 4; b++) press(b);
    checks++; if (ev_valid !== 1'b1) begin failures++; $display("FAIL ovf_full_valid got=%0b exp=1", ev_valid); end
    checks++; if (ev_id !== 2'd0) begin failures++; $display("FAIL ovf_head got=%0d exp=0", ev_id); end
    press(0);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_pending_only got=%0b exp=0", overflow); end
    press(0);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0b exp=1", overflow); end
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0b exp=0", overflow); end
  endtask

  task automatic test_full_pop();
    logic [1:0] ids [4];
    logic [1:0] exp_ids [4];
    int n;
    exp_ids[0] = 2'd1; exp_ids[1] = 2'd2; exp_ids[2] = 2'd3; exp_ids[3] = 2'd0;
    for (int k = 0; k < 4; k++) ids[k] = 2'bxx;
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
    checks++; if (ev_valid !== 1'b1) begin failures++; $display("FAIL fullpop_valid got=%0b exp=1", ev_valid); end
    checks++; if (ev_id !== 2'd1) begin failures++; $display("FAIL fullpop_head got=%0d exp=1", ev_id); end
    tick(1);
    n = 0;
    ev_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      if (ev_valid === 1'b1) begin
        if (n < 4) ids[n] = ev_id;
        n++;
      end
      tick(1);
    end
    ev_ready = 1'b0;
    checks++; if (n != 4) begin failures++; $display("FAIL fullpop_count got=%0d exp=4", n); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ids[k] !== exp_ids[k]) begin
        failures++; $display("FAIL fullpop_id%0d got=%0d exp=%0d", k, ids[k], exp_ids[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic vld_seen;
    ev_ready = 1'b0;
    press(1); press(2); press(3);
    checks++; if (ev_valid !== 1'b1) begin failures++; $display("FAIL mid_queued got=%0b exp=1", ev_valid); end
    btn_in[0] = 1'b1;
    tick(2);
    reset = 1'b0;
    #1;
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%0b exp=0", ev_valid); end
    checks++; if (ev_id !== 2'd0) begin failures++; $display("FAIL mid_rst_id got=%0d exp=0", ev_id); end
    checks++; if (btn_level !== 4'b0) begin failures++; $display("FAIL mid_rst_level got=%b exp=0000", btn_level); end
    tick(1);
    reset = 1'b1;
    vld_seen = 1'b0;
    repeat (20) begin
      tick(1);
      vld_seen |= ev_valid;
    end
    checks++; if (vld_seen !== 1'b0) begin failures++; $display("FAIL mid_held_event got=%0b exp=0", vld_seen); end
    checks++; if (btn_level !== 4'b0001) begin failures++; $display("FAIL mid_held_level got=%b exp=0001", btn_level); end
    btn_in[0] = 1'b0;
    repeat (10) begin
      tick(1);
      vld_seen |= ev_valid;
    end
    checks++; if (vld_seen !== 1'b0) begin failures++; $display("FAIL mid_release_event got=%0b exp=0", vld_seen); end
    btn_in[0] = 1'b1;
    tick(8);
    checks++; if (ev_valid !== 1'b1) begin failures++; $display("FAIL mid_repress_valid got=%0b exp=1", ev_valid); end
    checks++; if (ev_id !== 2'd0) begin failures++; $display("FAIL mid_repress_id got=%0d exp=0", ev_id); end
    btn_in = '0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    pulse_reset();
    test_burst(1);
    test_burst(2);
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
